// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB pipeline register and writeback formatter. It aligns
//               and extends big-endian sub-word loads, drives the register-file
//               write port and counts retired instructions.
//               Optional same-cycle forwarding is enabled by defining WB_FWD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_RegWr,
    input  logic [REG_AW-1:0] in_RW,
    input  logic              in_MemToReg,
    input  logic [2:0]        in_LoadType,
    input  logic [1:0]        in_AddrLo,
    input  logic [DATA_W-1:0] in_ALUOut,
    input  logic [DATA_W-1:0] in_MemData,
    output logic [DATA_W-1:0] BusW,
    output logic [REG_AW-1:0] RW,
    output logic              RegWr,
    output logic              wb_valid,
    output logic              addr_err,
    output logic [31:0]       retired
`ifdef WB_FWD_EN
    ,
    input  logic [REG_AW-1:0] fwd_RA,
    input  logic [REG_AW-1:0] fwd_RB,
    output logic              FwdA,
    output logic              FwdB,
    output logic [DATA_W-1:0] FwdData
`endif
);

    localparam logic [2:0] c_LT_LB  = 3'b001;
    localparam logic [2:0] c_LT_LBU = 3'b010;
    localparam logic [2:0] c_LT_LH  = 3'b011;
    localparam logic [2:0] c_LT_LHU = 3'b100;

    logic [DATA_W-1:0] r_busw;
    logic [REG_AW-1:0] r_rw;
    logic              r_regwr;
    logic              r_wb_valid;
    logic              r_addr_err;
    logic [31:0]       r_retired;

    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_busw;
    logic              w_is_half;
    logic              w_is_word;
    logic              w_misalign;
    logic              w_capture;
    logic              w_regwr;
    logic [31:0]       w_retired_nxt;

    // Big-endian lane selection: AddrLo 0 addresses the most significant byte.
    always_comb begin
        w_byte = 8'h00;
        case (in_AddrLo)
            2'd0:    w_byte = in_MemData[31:24];
            2'd1:    w_byte = in_MemData[23:16];
            2'd2:    w_byte = in_MemData[15:8];
            default: w_byte = in_MemData[7:0];
        endcase
        w_half = in_AddrLo[1] ? in_MemData[15:0] : in_MemData[31:16];
    end

    always_comb begin
        w_load = in_MemData;
        case (in_LoadType)
            c_LT_LB:  w_load = {{(DATA_W-8){w_byte[7]}}, w_byte};
            c_LT_LBU: w_load = {{(DATA_W-8){1'b0}}, w_byte};
            c_LT_LH:  w_load = {{(DATA_W-16){w_half[15]}}, w_half};
            c_LT_LHU: w_load = {{(DATA_W-16){1'b0}}, w_half};
            default:  w_load = in_MemData;
        endcase
    end

    // Unused encodings 101-111 behave as LW, including its alignment rule.
    assign w_is_half  = (in_LoadType == c_LT_LH) || (in_LoadType == c_LT_LHU);
    assign w_is_word  = (in_LoadType != c_LT_LB) && (in_LoadType != c_LT_LBU) && !w_is_half;
    assign w_misalign = in_valid & in_MemToReg &
                        ((w_is_half & in_AddrLo[0]) | (w_is_word & (in_AddrLo != 2'b00)));

    assign w_busw        = in_MemToReg ? w_load : in_ALUOut;
    assign w_regwr       = in_valid & in_RegWr & (in_RW != '0) & ~w_misalign;
    assign w_capture     = ~flush & ~stall;
    assign w_retired_nxt = r_retired + {31'd0, (w_capture & in_valid)};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busw     <= '0;
            r_rw       <= '0;
            r_regwr    <= 1'b0;
            r_wb_valid <= 1'b0;
            r_addr_err <= 1'b0;
        end else if (flush) begin
            // Squash keeps the data path so a held BusW/RW is never disturbed.
            r_regwr    <= 1'b0;
            r_wb_valid <= 1'b0;
            r_addr_err <= 1'b0;
        end else if (!stall) begin
            r_busw     <= w_busw;
            r_rw       <= in_RW;
            r_regwr    <= w_regwr;
            r_wb_valid <= in_valid;
            r_addr_err <= w_misalign;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= '0;
        end else begin
            r_retired <= w_retired_nxt;
        end
    end

    assign BusW     = r_busw;
    assign RW       = r_rw;
    assign RegWr    = r_regwr;
    assign wb_valid = r_wb_valid;
    assign addr_err = r_addr_err;
    assign retired  = r_retired;

`ifdef WB_FWD_EN
    // The register file's async read returns the old value during its write cycle.
    assign FwdA    = r_regwr & (r_rw == fwd_RA);
    assign FwdB    = r_regwr & (r_rw == fwd_RB);
    assign FwdData = r_busw;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Directed scoreboard bench for mem_wb_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        in_valid, in_RegWr, in_MemToReg;
    logic [4:0]  in_RW;
    logic [2:0]  in_LoadType;
    logic [1:0]  in_AddrLo;
    logic [31:0] in_ALUOut, in_MemData;
    logic [31:0] BusW;
    logic [4:0]  RW;
    logic        RegWr, wb_valid, addr_err;
    logic [31:0] retired;
`ifdef WB_FWD_EN
    logic [4:0]  fwd_RA, fwd_RB;
    logic        FwdA, FwdB;
    logic [31:0] FwdData;
`endif

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_RegWr(in_RegWr), .in_RW(in_RW),
        .in_MemToReg(in_MemToReg), .in_LoadType(in_LoadType), .in_AddrLo(in_AddrLo),
        .in_ALUOut(in_ALUOut), .in_MemData(in_MemData),
        .BusW(BusW), .RW(RW), .RegWr(RegWr), .wb_valid(wb_valid),
        .addr_err(addr_err), .retired(retired)
`ifdef WB_FWD_EN
        , .fwd_RA(fwd_RA), .fwd_RB(fwd_RB), .FwdA(FwdA), .FwdB(FwdB), .FwdData(FwdData)
`endif
    );

    typedef struct packed {
        logic [31:0] busw;
        logic [4:0]  rw;
        logic        regwr;
        logic        valid;
        logic        aerr;
        logic [31:0] ret;
        logic        chk_data;
    } exp_t;

    exp_t        sb[$];
    exp_t        m;
    int          total = 0;
    int          bad   = 0;

    function automatic logic [31:0] model_load(input logic [2:0] lt, input logic [1:0] lo,
                                               input logic [31:0] mem);
        logic [31:0] b, h;
        b = (mem >> (8 * (3 - int'(lo)))) & 32'h0000_00FF;
        h = (mem >> (16 * (1 - int'(lo[1])))) & 32'h0000_FFFF;
        case (lt)
            3'd1:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return mem;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic wr, input logic [4:0] rw,
                         input logic m2r, input logic [2:0] lt, input logic [1:0] lo,
                         input logic [31:0] alu, input logic [31:0] mem);
        in_valid = v; in_RegWr = wr; in_RW = rw; in_MemToReg = m2r;
        in_LoadType = lt; in_AddrLo = lo; in_ALUOut = alu; in_MemData = mem;
    endtask

    // Advance the model by one posedge, push the prediction, then compare.
    task automatic cycle();
        logic mis, is_half, is_word;
        exp_t e;
        is_half = (in_LoadType == 3'd3) || (in_LoadType == 3'd4);
        is_word = !(in_LoadType inside {3'd1, 3'd2, 3'd3, 3'd4});
        mis = in_valid & in_MemToReg & ((is_half & in_AddrLo[0]) | (is_word & (in_AddrLo != 2'd0)));
        if (rst) begin
            m = '0;
            m.chk_data = 1'b1;
        end else if (flush) begin
            m.valid = 1'b0; m.regwr = 1'b0; m.aerr = 1'b0;
        end else if (!stall) begin
            m.busw     = in_MemToReg ? model_load(in_LoadType, in_AddrLo, in_MemData) : in_ALUOut;
            m.rw       = in_RW;
            m.regwr    = in_valid & in_RegWr & (in_RW != 5'd0) & ~mis;
            m.valid    = in_valid;
            m.aerr     = mis;
            m.ret      = m.ret + (in_valid ? 32'd1 : 32'd0);
            m.chk_data = in_valid;
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.chk_data) begin
            check("BusW", BusW, e.busw);
            check("RW", {27'd0, RW}, {27'd0, e.rw});
        end
        check("RegWr", {31'd0, RegWr}, {31'd0, e.regwr});
        check("wb_valid", {31'd0, wb_valid}, {31'd0, e.valid});
        check("addr_err", {31'd0, addr_err}, {31'd0, e.aerr});
        check("retired", retired, e.ret);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        m = '0;
`ifdef WB_FWD_EN
        fwd_RA = 5'd0; fwd_RB = 5'd0;
`endif
        cycle(); cycle();
        rst = 1'b0;

        // ALU writeback
        drive(1, 1, 5'd5, 0, 3'd0, 2'd0, 32'h1234_5678, 32'hDEAD_BEEF); cycle();
        // Sub-word loads on 0x80FF_7F01
        drive(1, 1, 5'd1, 1, 3'd1, 2'd0, 32'h0, 32'h80FF_7F01); cycle();
        drive(1, 1, 5'd2, 1, 3'd2, 2'd0, 32'h0, 32'h80FF_7F01); cycle();
        drive(1, 1, 5'd4, 1, 3'd1, 2'd2, 32'h0, 32'h80FF_7F01); cycle();
        drive(1, 1, 5'd6, 1, 3'd3, 2'd2, 32'h0, 32'h80FF_7F01); cycle();
        drive(1, 1, 5'd8, 1, 3'd4, 2'd0, 32'h0, 32'h80FF_7F01); cycle();
        drive(1, 1, 5'd9, 1, 3'd2, 2'd3, 32'h0, 32'h80FF_7F01); cycle();
        drive(1, 1, 5'd10, 1, 3'd0, 2'd0, 32'h0, 32'hCAFE_F00D); cycle();
        drive(1, 1, 5'd11, 1, 3'd7, 2'd0, 32'h0, 32'h0BAD_F00D); cycle();
        // Misaligned LW, LH, LHU
        drive(1, 1, 5'd3, 1, 3'd0, 2'd1, 32'h0, 32'h1111_2222); cycle();
        drive(1, 1, 5'd12, 1, 3'd3, 2'd1, 32'h0, 32'h1111_2222); cycle();
        drive(1, 1, 5'd13, 1, 3'd4, 2'd3, 32'h0, 32'h1111_2222); cycle();
        drive(1, 1, 5'd14, 1, 3'd6, 2'd2, 32'h0, 32'h1111_2222); cycle();
        // ALU op ignores LoadType/AddrLo
        drive(1, 1, 5'd15, 0, 3'd0, 2'd1, 32'hA5A5_0001, 32'h0); cycle();
        // Stall three cycles with changing inputs
        stall = 1'b1;
        drive(1, 1, 5'd16, 0, 3'd0, 2'd0, 32'h0000_0016, 32'h0); cycle();
        drive(1, 1, 5'd17, 1, 3'd1, 2'd3, 32'h0, 32'hFFFF_FFFF); cycle();
        drive(0, 0, 5'd18, 0, 3'd0, 2'd0, 32'h0000_0018, 32'h0); cycle();
        stall = 1'b0;
        // Stall plus flush acts as flush
        stall = 1'b1; flush = 1'b1;
        drive(1, 1, 5'd19, 0, 3'd0, 2'd0, 32'h0000_0019, 32'h0); cycle();
        stall = 1'b0; flush = 1'b0;
        // Write to r0 is suppressed but retires
        drive(1, 1, 5'd0, 0, 3'd0, 2'd0, 32'h7777_0000, 32'h0); cycle();
        // Bubble
        drive(0, 1, 5'd20, 0, 3'd0, 2'd0, 32'h0, 32'h0); cycle();
        // Non-writing instruction retires
        drive(1, 0, 5'd21, 0, 3'd0, 2'd0, 32'h0000_0021, 32'h0); cycle();
        // Plain flush
        flush = 1'b1;
        drive(1, 1, 5'd22, 0, 3'd0, 2'd0, 32'h0000_0022, 32'h0); cycle();
        flush = 1'b0;
        drive(1, 1, 5'd7, 0, 3'd0, 2'd0, 32'h0000_0707, 32'h0); cycle();
`ifdef WB_FWD_EN
        fwd_RA = 5'd7; fwd_RB = 5'd8;
        #1;
        check("FwdA", {31'd0, FwdA}, 32'd1);
        check("FwdB", {31'd0, FwdB}, 32'd0);
        check("FwdData", FwdData, 32'h0000_0707);
`endif
        // Reset mid-stream for two cycles
        rst = 1'b1;
        drive(1, 1, 5'd23, 0, 3'd0, 2'd0, 32'h0000_0023, 32'h0); cycle(); cycle();
        rst = 1'b0;
        drive(1, 1, 5'd24, 0, 3'd0, 2'd0, 32'h0000_0024, 32'h0); cycle();
        // Counter wrap: preload the counter while stalled, then retire once
        force dut.r_retired = 32'hFFFF_FFFF;
        m.ret = 32'hFFFF_FFFF;
        stall = 1'b1;
        drive(1, 1, 5'd25, 0, 3'd0, 2'd0, 32'h0000_0025, 32'h0); cycle();
        release dut.r_retired;
        stall = 1'b0;
        drive(1, 1, 5'd26, 0, 3'd0, 2'd0, 32'h0000_0026, 32'h0); cycle();
        drive(1, 1, 5'd27, 0, 3'd0, 2'd0, 32'h0000_0027, 32'h0); cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
